// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: drains a first-word-fall-through FIFO and packs PACK_RATIO narrow entries
// into one wide word on a valid/ready master stream. A flush emits a partial word with
// per-lane keep bits. Optional idle-timeout auto-flush when FLUSH_TIMEOUT_EN is defined.
module fifo_rd_packer #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned PACK_RATIO     = 4,
  parameter int unsigned CNT_WIDTH      = $clog2(PACK_RATIO),
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             clear,
  input  logic                             flush,
  output logic                             fifo_ren,
  input  logic [DATA_WIDTH-1:0]            fifo_rdata,
  input  logic                             fifo_empty,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [DATA_WIDTH*PACK_RATIO-1:0] m_data,
  output logic [PACK_RATIO-1:0]            m_keep,
  output logic                             busy
);

  localparam logic [CNT_WIDTH-1:0] LastCnt = CNT_WIDTH'(PACK_RATIO - 1);

  if (PACK_RATIO < 2 || TIMEOUT_CYCLES < 1) begin : g_cfg_check
    $error("fifo_rd_packer: PACK_RATIO must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  // The last lane is never stored: it goes straight from fifo_rdata into the output word.
  logic [PACK_RATIO-2:0][DATA_WIDTH-1:0]  lane_q, lane_d;
  logic [CNT_WIDTH-1:0]                   acc_cnt_q, acc_cnt_d;
  logic [DATA_WIDTH*PACK_RATIO-1:0]       m_data_q, m_data_d;
  logic [PACK_RATIO-1:0]                  m_keep_q, m_keep_d;
  logic                                   m_valid_q, m_valid_d;
  logic                                   flush_pend_q, flush_pend_d;

  logic out_free;
  logic at_last;
  logic rd;
  logic flush_emit;

`ifdef FLUSH_TIMEOUT_EN
  localparam int unsigned TmrWidth = $clog2(TIMEOUT_CYCLES + 1);
  logic [TmrWidth-1:0] tmr_q, tmr_d;
`endif

  // Read decision, accumulation, word completion, flush emission and clear.
  always_comb begin
    out_free   = !m_valid_q || m_ready;
    at_last    = (acc_cnt_q == LastCnt);
    rd         = rst_n && !fifo_empty && !clear && !flush_pend_q && (!at_last || out_free);
    flush_emit = 1'b0;

    lane_d       = lane_q;
    acc_cnt_d    = acc_cnt_q;
    m_data_d     = m_data_q;
    m_keep_d     = m_keep_q;
    m_valid_d    = m_valid_q && !m_ready;
    flush_pend_d = flush_pend_q;

    if (rd) begin
      if (at_last) begin
        m_data_d  = {fifo_rdata, lane_q};
        m_keep_d  = '1;
        m_valid_d = 1'b1;
        acc_cnt_d = '0;
      end else begin
        for (int unsigned i = 0; i < PACK_RATIO - 1; i++) begin
          if (acc_cnt_q == CNT_WIDTH'(i)) lane_d[i] = fifo_rdata;
        end
        acc_cnt_d = acc_cnt_q + CNT_WIDTH'(1);
      end
    end

    // Reads are blocked while a flush is pending, so this never collides with a read.
    if (flush_pend_q) begin
      if (acc_cnt_q == '0) begin
        flush_pend_d = 1'b0;
      end else if (out_free) begin
        flush_emit = 1'b1;
        m_data_d   = '0;
        m_keep_d   = '0;
        for (int unsigned i = 0; i < PACK_RATIO - 1; i++) begin
          if (CNT_WIDTH'(i) < acc_cnt_q) begin
            m_data_d[i*DATA_WIDTH +: DATA_WIDTH] = lane_q[i];
            m_keep_d[i]                          = 1'b1;
          end
        end
        m_valid_d    = 1'b1;
        acc_cnt_d    = '0;
        flush_pend_d = 1'b0;
      end
    end

`ifdef FLUSH_TIMEOUT_EN
    tmr_d = tmr_q;
    if (rd || flush_emit) begin
      tmr_d = '0;
    end else if (acc_cnt_q != '0 && !flush_pend_q) begin
      if (tmr_q == TmrWidth'(TIMEOUT_CYCLES - 1)) begin
        tmr_d        = '0;
        flush_pend_d = 1'b1;
      end else begin
        tmr_d = tmr_q + TmrWidth'(1);
      end
    end
`endif

    // A flush arriving with a completing read is taken after the read.
    if (flush) flush_pend_d = 1'b1;

    if (clear) begin
      m_valid_d    = 1'b0;
      m_keep_d     = '0;
      acc_cnt_d    = '0;
      flush_pend_d = 1'b0;
`ifdef FLUSH_TIMEOUT_EN
      tmr_d        = '0;
`endif
    end
  end

  // Accumulator, output register and flush-pending state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q       <= '0;
      acc_cnt_q    <= '0;
      m_data_q     <= '0;
      m_keep_q     <= '0;
      m_valid_q    <= 1'b0;
      flush_pend_q <= 1'b0;
    end else begin
      lane_q       <= lane_d;
      acc_cnt_q    <= acc_cnt_d;
      m_data_q     <= m_data_d;
      m_keep_q     <= m_keep_d;
      m_valid_q    <= m_valid_d;
      flush_pend_q <= flush_pend_d;
    end
  end

`ifdef FLUSH_TIMEOUT_EN
  // Idle counter for the automatic flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmr_q <= '0;
    else        tmr_q <= tmr_d;
  end
`endif

  // Output drive.
  always_comb begin
    fifo_ren = rd;
    m_valid  = m_valid_q;
    m_data   = m_data_q;
    m_keep   = m_keep_q;
    busy     = (acc_cnt_q != '0) || m_valid_q || flush_pend_q;
  end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Self-checking bench for fifo_rd_packer (DATA_WIDTH=8, PACK_RATIO=4, TIMEOUT_CYCLES=16).
module tb_fifo_rd_packer;
  localparam int unsigned DW = 8;
  localparam int unsigned R  = 4;
  localparam int unsigned TO = 16;

  logic          clk, rst_n, clear, flush, fifo_ren, fifo_empty, m_valid, m_ready, busy;
  logic [DW-1:0] fifo_rdata;
  logic [31:0]   m_data;
  logic [3:0]    m_keep;

  fifo_rd_packer #(
    .DATA_WIDTH(DW), .PACK_RATIO(R), .CNT_WIDTH(2), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .flush(flush),
    .fifo_ren(fifo_ren), .fifo_rdata(fifo_rdata), .fifo_empty(fifo_empty),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_keep(m_keep), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [7:0]  fq[$];   // FIFO contents seen by the DUT
  logic [35:0] got[$];  // words accepted downstream {data, keep}

  // Reference model: pending lanes as a byte list, output register, flush request.
  logic [7:0]  mq[$];
  bit          mv, mpend;
  logic [31:0] md;
  logic [3:0]  mk;
`ifdef FLUSH_TIMEOUT_EN
  int          idle;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mv = 0; mpend = 0; md = '0; mk = '0; mq.delete();
`ifdef FLUSH_TIMEOUT_EN
    idle = 0;
`endif
  endtask

  function automatic logic [31:0] pack_bytes(input int n);
    logic [31:0] w = '0;
    for (int i = 0; i < n; i++) w |= 32'(mq[i]) << (8 * i);
    return w;
  endfunction

  // One clock cycle: apply inputs at negedge, compare, advance model, retire FIFO read.
  task automatic cyc(input logic clr, input logic fl, input logic rdy);
    logic ren_e, ren_s, nv, npend, emitted;
    int   n;
    clear = clr; flush = fl; m_ready = rdy;
    fifo_empty = (fq.size() == 0);
    fifo_rdata = fifo_empty ? 8'h00 : fq[0];
    #1;
    n     = mq.size();
    ren_e = !fifo_empty && !clr && !mpend && (n < R - 1 || !mv || rdy);
    chk("fifo_ren", fifo_ren, ren_e);
    chk("m_valid", m_valid, mv);
    chk("busy", busy, (n != 0) || mv || mpend);
    if (mv) begin
      chk("m_data", m_data, md);
      chk("m_keep", m_keep, mk);
    end
    if (m_valid && m_ready) got.push_back({m_data, m_keep});
    ren_s = fifo_ren;

    nv = mv && !rdy; npend = mpend; emitted = 0;
    if (ren_e) begin
      if (n == R - 1) begin
        md = pack_bytes(n) | (32'(fifo_rdata) << (8 * (R - 1)));
        mk = 4'hf; nv = 1; mq.delete(); emitted = 1;
      end else begin
        mq.push_back(fifo_rdata);
      end
    end else if (mpend) begin
      if (n == 0) npend = 0;
      else if (!mv || rdy) begin
        md = pack_bytes(n); mk = 4'((1 << n) - 1);
        nv = 1; mq.delete(); npend = 0; emitted = 1;
      end
    end
`ifdef FLUSH_TIMEOUT_EN
    if (ren_e || emitted) idle = 0;
    else if (n > 0 && !mpend) begin
      idle++;
      if (idle == TO) begin npend = 1; idle = 0; end
    end
`endif
    if (fl) npend = 1;
    if (clr) begin
      nv = 0; mk = '0; mq.delete(); npend = 0;
`ifdef FLUSH_TIMEOUT_EN
      idle = 0;
`endif
    end
    mv = nv; mpend = npend;

    @(posedge clk);
    if (ren_s && fq.size() != 0) void'(fq.pop_front());
    @(negedge clk);
  endtask

  task automatic run(input int n, input logic rdy);
    repeat (n) cyc(1'b0, 1'b0, rdy);
  endtask

  initial begin
    clk = 0; rst_n = 1; clear = 0; flush = 0; m_ready = 0;
    fifo_empty = 1; fifo_rdata = '0;
    #1 rst_n = 0;
    // fifo_ren must stay low under reset even with data available
    fq.push_back(8'h99); fifo_empty = 0; fifo_rdata = 8'h99;
    #2;
    chk("rst_ren", fifo_ren, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_keep", m_keep, 0);
    chk("rst_busy", busy, 0);
    fq.delete(); fifo_empty = 1;
    @(negedge clk);
    rst_n = 1;
    model_reset();

    // Full word, streaming
    got.delete();
    fq.push_back(8'h11); fq.push_back(8'h22); fq.push_back(8'h33); fq.push_back(8'h44);
    run(8, 1);
    chk("s1_count", got.size(), 1);
    chk("s1_word", got[0], {32'h44332211, 4'hf});

    // Backpressure: second word stalls on its last entry
    got.delete();
    for (int i = 1; i <= 8; i++) fq.push_back(8'(i * 8'h11));
    run(12, 0);
    chk("s2_stall_left", fq.size(), 1);
    chk("s2_none_yet", got.size(), 0);
    run(6, 1);
    chk("s2_count", got.size(), 2);
    chk("s2_w0", got[0], {32'h44332211, 4'hf});
    chk("s2_w1", got[1], {32'h88776655, 4'hf});

    // Partial flush
    got.delete();
    fq.push_back(8'hAA); fq.push_back(8'hBB);
    run(4, 1);
    cyc(1'b0, 1'b1, 1'b1);
    run(5, 1);
    chk("s3_count", got.size(), 1);
    chk("s3_word", got[0], {32'h0000BBAA, 4'b0011});
    chk("s3_busy", busy, 0);

    // Flush with nothing held: pending for one cycle, no word
    got.delete();
    cyc(1'b0, 1'b1, 1'b1);
    chk("s4_pend", busy, 1);
    run(3, 1);
    chk("s4_idle", busy, 0);
    chk("s4_count", got.size(), 0);

    // Clear drops held lanes
    got.delete();
    fq.push_back(8'h01); fq.push_back(8'h02);
    run(4, 1);
    cyc(1'b1, 1'b0, 1'b1);
    fq.push_back(8'h10); fq.push_back(8'h20); fq.push_back(8'h30); fq.push_back(8'h40);
    run(8, 1);
    chk("s5_count", got.size(), 1);
    chk("s5_word", got[0], {32'h40302010, 4'hf});

    // Single entry left idle
    got.delete();
    fq.push_back(8'h5A);
    run(25, 1);
`ifdef FLUSH_TIMEOUT_EN
    chk("s6_count", got.size(), 1);
    chk("s6_word", got[0], {32'h0000005A, 4'b0001});
`else
    chk("s6_count", got.size(), 0);
    chk("s6_held", busy, 1);
    cyc(1'b0, 1'b1, 1'b1);
    run(4, 1);
    chk("s6_flushed", got[0], {32'h0000005A, 4'b0001});
`endif

    // Asynchronous reset mid-word discards held data
    got.delete();
    fq.push_back(8'h01);
    run(3, 1);
    rst_n = 0;
    #1;
    chk("s7_busy", busy, 0);
    chk("s7_valid", m_valid, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    fq.push_back(8'h02); fq.push_back(8'h03); fq.push_back(8'h04); fq.push_back(8'h05);
    run(8, 1);
    chk("s7_count", got.size(), 1);
    chk("s7_word", got[0], {32'h05040302, 4'hf});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
